// File: rtl/cpu_sequencer_if.sv
// Loader-to-sequencer program stream: valid/ready handshake carrying one
// instruction word per transfer, with prog_last marking the final word.
interface cpu_sequencer_if;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_last;
  logic       prog_ready;

  modport master (output prog_valid, output prog_data, output prog_last, input  prog_ready);
  modport slave  (input  prog_valid, input  prog_data, input  prog_last, output prog_ready);
endinterface

// File: rtl/cpu_sequencer.sv
// Sequencer in front of the control unit: streams a program into instruction
// memory, then alternates fetch/execute until HALT, watchdog expiry, or stepping.
module cpu_sequencer #(
  parameter int unsigned MEM_DEPTH   = 16,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF,
  parameter int unsigned MAX_INSTR   = 200
) (
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.slave   prog,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [7:0]       instr,
  output logic             state,
  output logic             load,
  output logic [7:0]       instr_i,
  output logic             loaded,
  output logic             running,
  output logic             halted,
  output logic             timeout,
  output logic [7:0]       instr_cnt
);

  localparam int unsigned CNT_W = $clog2(MEM_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, EXEC, STOP} fsm_t;

  fsm_t             cur, nxt;
  logic [CNT_W-1:0] load_cnt;
  logic             accept;
  logic             last_word;
  logic             is_halt;
  logic             hit_max;
  logic [8:0]       cnt_plus;

  always_comb begin
    prog.prog_ready = (cur == LOAD);
    accept          = prog.prog_valid && (cur == LOAD);
    load            = accept;
    instr_i         = accept ? prog.prog_data : '0;
    state           = (cur == EXEC);
    running         = (cur == FETCH) || (cur == EXEC);
    last_word       = prog.prog_last || (load_cnt == CNT_W'(MEM_DEPTH - 1));
    is_halt         = (instr == HALT_OPCODE);
    cnt_plus        = {1'b0, instr_cnt} + 9'd1;
    hit_max         = (cnt_plus == 9'(MAX_INSTR));
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  if (prog.prog_valid)       nxt = LOAD;
             else if (start && loaded)  nxt = FETCH;
      LOAD:  if (accept && last_word)   nxt = IDLE;
      FETCH: if (!step_mode || step)    nxt = EXEC;
      EXEC:  nxt = (is_halt || hit_max) ? STOP : FETCH;
      STOP:  if (!start)                nxt = IDLE;
      default:                          nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  // Status/counter registers follow the same state decode as the FSM above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      loaded    <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      case (cur)
        IDLE: begin
          if (prog.prog_valid) begin
            loaded   <= 1'b0;
            halted   <= 1'b0;
            timeout  <= 1'b0;
            load_cnt <= '0;
          end else if (start && loaded) begin
            instr_cnt <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            load_cnt <= load_cnt + CNT_W'(1);
            if (last_word) loaded <= 1'b1;
          end
        end
        EXEC: begin
          instr_cnt <= cnt_plus[8] ? 8'hFF : cnt_plus[7:0];
          if (is_halt)      halted  <= 1'b1;
          else if (hit_max) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
